// File: rtl/mux4_arb_pkg.sv
// Shared constants, FSM encoding and helpers for the mux4 round-robin arbiter.
// Imported by the winner picker and the arbiter top.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // Reset value of the last-owner pointer: requester 0 is searched first.
  localparam logic [SEL_W-1:0] LAST_RESET = 2'd3;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4.sv
// Plain four-input data multiplexer driven by the arbiter's registered sel.
// Kept separate so the arbiter itself never carries data.
module mux4 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] a2,
  input  logic [W-1:0] a3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  assign y = sel[1] ? (sel[0] ? a3 : a2) : (sel[0] ? a1 : a0);

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin search over four requesters, starting one past
// the most recent owner and wrapping modulo four.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   winner,
  output logic               found
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset to the nearest so the nearest set bit,
  // visited last, overrides any earlier candidate.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    winner = last;
    found  = 1'b0;
    cand   = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last + k[SEL_W-1:0];
      if (req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for a mux4: one-hot grant, registered select and busy,
// bounded hold time per owner and a one-cycle dead gap between owners.
module mux4_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [SEL_W-1:0]   sel_d;
  logic               busy_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [3:0]         hold_q, hold_d;

  logic [SEL_W-1:0]   winner;
  logic               found;
  logic               owner_req;

  rr_pick4 u_pick (
    .req    (req),
    .last   (last_q),
    .winner (winner),
    .found  (found)
  );

  // During GRANT the last-owner pointer is the current owner.
  assign owner_req = req[last_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = sel;
    busy_d  = busy;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE, GAP: begin
        // sel is left untouched so the downstream mux sees no glitch.
        gnt_d   = '0;
        busy_d  = 1'b0;
        hold_d  = 4'd0;
        state_d = IDLE;
        if (found) begin
          state_d = GRANT;
          gnt_d   = idx_to_onehot(winner);
          sel_d   = winner;
          busy_d  = 1'b1;
          last_d  = winner;
          hold_d  = 4'd1;
        end
      end
      GRANT: begin
        if (!owner_req || hold_q == HOLD_LIM) begin
          state_d = GAP;
          gnt_d   = '0;
          busy_d  = 1'b0;
          hold_d  = 4'd0;
        end else if (hold_q != 4'hF) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        hold_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      last_q  <= LAST_RESET;
      hold_q  <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous cycle's state, independent of order.
      state_q <= state_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      busy    <= busy_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_busy_gnt    : assert property (@(posedge clk) disable iff (!rst_n) busy == (|gnt));

endmodule

// File: tb/tb_mux4_arbiter.sv
// Bench for mux4_arbiter: directed vector tables, hand-written reset cases and
// random requests compared against a queue-free behavioural arbitration model.
module tb_mux4_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt, gnt1;
  logic [1:0] sel, sel1;
  logic       busy, busy1;
  logic [7:0] a [4];
  logic [7:0] mux_y;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux4_arbiter #(.HOLD_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .sel(sel), .busy(busy)
  );

  mux4_arbiter #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt1), .sel(sel1), .busy(busy1)
  );

  mux4 #(.W(8)) u_mux (
    .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]), .sel(sel), .y(mux_y)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner = -1 means nobody holds the grant.
  typedef struct {
    int owner;
    int last;
    int sel;
    int cnt;
  } model_t;

  model_t m [2];
  int     hold_max [2] = '{4, 1};

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].owner = -1;
      m[i].last  = 3;
      m[i].sel   = 0;
      m[i].cnt   = 0;
    end
  endfunction

  function automatic void model_step(input logic [3:0] r);
    for (int i = 0; i < 2; i++) begin
      if (m[i].owner >= 0) begin
        if (!r[m[i].owner] || m[i].cnt == hold_max[i]) m[i].owner = -1;
        else m[i].cnt++;
      end else begin
        for (int k = 1; k <= 4; k++) begin
          int idx;
          idx = (m[i].last + k) % 4;
          if (r[idx]) begin
            m[i].owner = idx;
            m[i].last  = idx;
            m[i].sel   = idx;
            m[i].cnt   = 1;
            break;
          end
        end
      end
    end
  endfunction

  function automatic logic [6:0] model_out(input int i);
    logic [3:0] g;
    g = (m[i].owner >= 0) ? 4'(1 << m[i].owner) : 4'd0;
    return {g, 2'(m[i].sel), m[i].owner >= 0};
  endfunction

  // Called at a negedge; ends at the following negedge with both DUTs compared.
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    for (int k = 0; k < 4; k++) a[k] = 8'($urandom);
    model_step(r);
    @(negedge clk);
    check("model_h4", {gnt, sel, busy}, model_out(0));
    check("model_h1", {gnt1, sel1, busy1}, model_out(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    @(negedge clk);
    check("reset_h4", {gnt, sel, busy}, 7'h00);
    check("reset_h1", {gnt1, sel1, busy1}, 7'h00);
    rst_n = 1'b1;
  endtask

  // Structural invariants on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("onehot_h4", 32'($onehot0(gnt)), 1);
      check("onehot_h1", 32'($onehot0(gnt1)), 1);
      check("busy_h4", busy, |gnt);
      if (busy) check("sel_idx_h4", gnt[sel], 1'b1);
      if (busy1) check("sel_idx_h1", gnt1[sel1], 1'b1);
      check("mux_out", mux_y, a[sel]);
    end
  end

  typedef struct {
    bit         rst_first;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input bit rf, input logic [3:0] r, input logic [3:0] g,
                              input logic [1:0] s, input logic b);
    vec_t v;
    v.rst_first = rf;
    v.req = r;
    v.gnt = g;
    v.sel = s;
    v.busy = b;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [3:0] exp_h1 [4];
    logic [3:0] cur;

    rst_n = 1'b0;
    req   = 4'b0000;
    for (int k = 0; k < 4; k++) a[k] = 8'($urandom);
    model_reset();

    // Single requester held: four-cycle hold, gap, re-grant.
    add(1, 4'b0001, 4'b0001, 2'd0, 1'b1);
    for (int c = 0; c < 3; c++) add(0, 4'b0001, 4'b0001, 2'd0, 1'b1);
    add(0, 4'b0001, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0001, 4'b0001, 2'd0, 1'b1);
    // All four requesting: rotation 0,1,2,3,0 with gaps.
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < ((g == 4) ? 1 : 4); c++)
        add((g == 0 && c == 0), 4'b1111, 4'(1 << (g % 4)), 2'(g % 4), 1'b1);
      if (g < 4) add(0, 4'b1111, 4'b0000, 2'(g % 4), 1'b0);
    end
    // Short request from 2, then idle with sel parked at 2.
    add(1, 4'b0100, 4'b0100, 2'd2, 1'b1);
    add(0, 4'b0100, 4'b0100, 2'd2, 1'b1);
    add(0, 4'b0000, 4'b0000, 2'd2, 1'b0);
    add(0, 4'b0000, 4'b0000, 2'd2, 1'b0);
    add(0, 4'b0000, 4'b0000, 2'd2, 1'b0);
    // Late request from 0 does not disturb owner 2, then wins after the gap.
    add(1, 4'b0100, 4'b0100, 2'd2, 1'b1);
    for (int c = 0; c < 3; c++) add(0, 4'b0101, 4'b0100, 2'd2, 1'b1);
    add(0, 4'b0101, 4'b0000, 2'd2, 1'b0);
    add(0, 4'b0101, 4'b0001, 2'd0, 1'b1);

    foreach (tbl[i]) begin
      if (tbl[i].rst_first) do_reset();
      step(tbl[i].req);
      check($sformatf("vec%0d", i), {gnt, sel, busy}, {tbl[i].gnt, tbl[i].sel, tbl[i].busy});
    end

    // HOLD_MAX = 1: every grant is a single cycle followed by a gap.
    exp_h1 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(4'b0011);
      check($sformatf("h1_seq%0d", c), gnt1, exp_h1[c]);
    end

    // Asynchronous reset in the middle of a grant to requester 3.
    do_reset();
    step(4'b1000);
    check("pre_async_gnt", {gnt, sel, busy}, {4'b1000, 2'd3, 1'b1});
    #2;
    req   = 4'b1001;
    rst_n = 1'b0;
    #1;
    check("async_rst_h4", {gnt, sel, busy}, 7'h00);
    check("async_rst_h1", {gnt1, sel1, busy1}, 7'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check("post_release_idle", {gnt, sel, busy}, 7'h00);
    step(4'b1001);
    check("post_rst_winner", {gnt, sel, busy}, {4'b0001, 2'd0, 1'b1});

    // Random requests with occasional resets.
    cur = 4'b0000;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      if ($urandom_range(0, 2) == 0) cur = 4'($urandom);
      step(cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux4_arbiter.md
MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 4, maximum consecutive cycles one requester may hold a grant (legal range 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  level request; bit i means requester i wants mux input ai.
REQ-005 Port: gnt  output  4  registered one-hot grant; all-zero when no owner.
REQ-006 Port: sel  output  2  registered select for the downstream mux4 sel input; equals the index of the current owner.
REQ-007 Port: busy  output  1  registered; high while any gnt bit is high.

Function
REQ-008 The block SHALL implement FSM states IDLE, GRANT and GAP, with IDLE as the reset state.
REQ-009 IDLE: if req != 0, SHALL select a winner and enter GRANT; the winner's gnt bit rises on the next posedge, one cycle of latency from req.
REQ-010 Winner selection SHALL be round-robin: search indices last+1, last+2, ... modulo 4, where last is the most recent owner; the first set req bit wins.
REQ-011 On entering GRANT, sel SHALL take the winner index in the same cycle gnt rises, and last SHALL update to the winner.
REQ-012 GRANT: a hold counter SHALL start at 1 on the first grant cycle and increment each cycle; it is 4 bits wide and never wraps.
REQ-013 GRANT SHALL exit to GAP when req[owner] is low, or when the counter equals HOLD_MAX, whichever occurs first.
REQ-014 GAP SHALL last exactly one cycle, with gnt = 0 and busy = 0; sel SHALL hold its previous value (no glitch to the mux).
REQ-015 GAP SHALL arbitrate exactly as IDLE; if req != 0 it enters GRANT, otherwise IDLE.
REQ-016 A requester that is preempted by HOLD_MAX and keeps req high SHALL re-compete normally and wins only if no other index lies ahead of it in round-robin order.
REQ-017 Simultaneous requests SHALL resolve purely by round-robin order; at most one gnt bit is ever high.
REQ-018 Changes to non-owner req bits during GRANT SHALL NOT affect the current grant.
REQ-019 With HOLD_MAX = 1, every grant SHALL last one cycle, followed by GAP.

Reset
REQ-020 Asserting rst_n low SHALL immediately force gnt = 0, sel = 2'b00, busy = 0, the hold counter to 0, the FSM to IDLE and last = 3, so requester 0 has first priority.
REQ-021 Reset asserted mid-grant SHALL drop gnt asynchronously; after release, arbitration restarts from the last = 3 state.
REQ-022 Reset deassertion SHALL be followed by at least one cycle in IDLE before any gnt rises.

Structure
REQ-023 The FSM state encoding, the NUM_REQ = 4 constant and the SEL_W = 2 constant SHALL reside in a shared package, mux4_arb_pkg.
REQ-024 The round-robin winner search SHALL be one combinational sub-module, rr_pick4, with inputs req[3:0] and last[1:0] and outputs winner[1:0] and found.
REQ-025 A top-level integration SHALL connect sel directly to the mux4 sel input; the arbiter itself SHALL NOT route data.

Verification
REQ-026 Reset, then req = 4'b0001 held: gnt = 0001 and sel = 00 from cycle 1, released after 4 cycles, GAP, then re-granted to 0001.
REQ-027 req = 4'b1111 held with HOLD_MAX = 4: grant sequence 0001, 0010, 0100, 1000, 0001, each lasting 4 cycles and separated by one GAP cycle.
REQ-028 req = 4'b0100 for 2 cycles, then 0: gnt = 0100 for 2 cycles, GAP with sel held at 10, then IDLE with busy = 0.
REQ-029 During a grant to requester 2, raise req[0]: the grant to 2 is unaffected; after GAP, requester 0 wins with sel = 00.
REQ-030 rst_n pulsed low while gnt = 1000: gnt = 0, sel = 00 and busy = 0 without waiting for a clock edge; the next grant with req = 4'b1001 goes to requester 0.
REQ-031 Every scenario SHALL check, via a bench monitor, that gnt is one-hot-or-zero, that sel equals the index of the gnt bit whenever busy = 1, and that mux_out equals a[sel].
